// File: rtl/ota_trim_cal_ctrl.sv
// Trim/offset controller for NCH OTA channels: holds a trim code per channel,
// accepts manual writes when idle and runs a per-channel SAR offset calibration.
module ota_trim_cal_ctrl #(
    parameter int               NCH        = 2,
    parameter int               TRIM_W     = 6,
    parameter int               SETTLE_CYC = 16,
    parameter logic [NCH-1:0]   CAL_MASK   = {NCH{1'b1}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [2:0]               cfg_ch,
    input  logic [TRIM_W-1:0]        cfg_code,
    input  logic                     cal_start,
    input  logic                     cmp_in,
    output logic                     busy,
    output logic                     done,
    output logic [NCH-1:0]           cal_sel,
    output logic [NCH*TRIM_W-1:0]    trim_out,
    output logic [NCH-1:0]           sat,
    output logic                     err
);

    localparam int                BIT_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam int                CNT_W = $clog2(SETTLE_CYC);
    localparam logic [TRIM_W-1:0] MID   = {1'b1, {(TRIM_W-1){1'b0}}};
    // Mask widened to 8 bits so the 3-bit channel index selects it without truncation.
    localparam logic [7:0]        MASK8 = 8'(CAL_MASK);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_SETTLE, S_SAMPLE, S_NEXT_CH, S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [2:0]          ch_reg;
    logic [BIT_W-1:0]    bit_reg;
    logic [TRIM_W-1:0]   trial_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [NCH-1:0]      cal_sel_reg;
    logic [NCH-1:0]      sat_reg;
    logic                err_reg;
    logic                cmp_meta_reg, cmp_s_reg;
    logic [TRIM_W-1:0]   code_reg [NCH];
    logic [TRIM_W-1:0]   sar_code;
    logic                cfg_wr;
    logic                last_ch;

    assign busy      = (state_reg != S_IDLE);
    assign cfg_ready = ~busy;
    assign done      = (state_reg == S_DONE);
    assign cal_sel   = cal_sel_reg;
    assign sat       = sat_reg;
    assign err       = err_reg;
    assign cfg_wr    = cfg_valid & cfg_ready;
    assign last_ch   = ({1'b0, ch_reg} == 4'(NCH - 1));

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_trim
            assign trim_out[gi*TRIM_W +: TRIM_W] = code_reg[gi];
        end
    endgenerate

    // SAR step: drop the bit under test when the comparator says "too high",
    // then tentatively set the next lower bit.
    always_comb begin
        sar_code = trial_reg;
        if (cmp_s_reg)
            sar_code[bit_reg] = 1'b0;
        if (bit_reg != '0)
            sar_code[bit_reg - 1'b1] = 1'b1;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (cal_start) state_next = S_SEL;
            S_SEL:     state_next = MASK8[ch_reg] ? S_SETTLE : S_NEXT_CH;
            S_SETTLE:  if (cnt_reg == CNT_W'(SETTLE_CYC - 1)) state_next = S_SAMPLE;
            S_SAMPLE:  state_next = (bit_reg == '0) ? S_NEXT_CH : S_SETTLE;
            S_NEXT_CH: state_next = last_ch ? S_DONE : S_SEL;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_reg       <= '0;
            bit_reg      <= '0;
            trial_reg    <= '0;
            cnt_reg      <= '0;
            cal_sel_reg  <= '0;
            sat_reg      <= '0;
            err_reg      <= 1'b0;
            cmp_meta_reg <= 1'b0;
            cmp_s_reg    <= 1'b0;
            for (int i = 0; i < NCH; i++)
                code_reg[i] <= MID;
        end else begin
            cmp_meta_reg <= cmp_in;
            cmp_s_reg    <= cmp_meta_reg;
            case (state_reg)
                S_IDLE: begin
                    if (cfg_wr) begin
                        if ({1'b0, cfg_ch} < 4'(NCH)) begin
                            for (int i = 0; i < NCH; i++)
                                if (cfg_ch == 3'(i))
                                    code_reg[i] <= cfg_code;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                    if (cal_start) begin
                        ch_reg  <= '0;
                        sat_reg <= sat_reg & ~CAL_MASK;
                    end
                end
                S_SEL: begin
                    if (MASK8[ch_reg]) begin
                        trial_reg <= MID;
                        bit_reg   <= BIT_W'(TRIM_W - 1);
                        cnt_reg   <= '0;
                        for (int i = 0; i < NCH; i++) begin
                            cal_sel_reg[i] <= (ch_reg == 3'(i));
                            if (ch_reg == 3'(i))
                                code_reg[i] <= MID;
                        end
                    end
                end
                S_SETTLE: cnt_reg <= cnt_reg + 1'b1;
                S_SAMPLE: begin
                    trial_reg <= sar_code;
                    cnt_reg   <= '0;
                    for (int i = 0; i < NCH; i++) begin
                        if (ch_reg == 3'(i)) begin
                            code_reg[i] <= sar_code;
                            if (bit_reg == '0)
                                sat_reg[i] <= (sar_code == '0) | (sar_code == '1);
                        end
                    end
                    if (bit_reg != '0)
                        bit_reg <= bit_reg - 1'b1;
                end
                S_NEXT_CH: begin
                    cal_sel_reg <= '0;
                    if (!last_ch)
                        ch_reg <= ch_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ota_trim_cal_ctrl.sv
// Randomised bench for ota_trim_cal_ctrl: two instances (all channels / channel 1 only
// calibrated) checked against a reference model of codes, sat, err and sweep latency.
module tb_ota_trim_cal_ctrl;

    localparam int         NCH    = 2;
    localparam int         TW     = 6;
    localparam int         SC     = 4;
    localparam logic [1:0] MASK_A = 2'b11;
    localparam logic [1:0] MASK_M = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cal_start = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic [5:0]  cfg_code = '0;
    logic        cmp_a, cmp_m;
    logic        rdy_a, busy_a, done_a, err_a;
    logic        rdy_m, busy_m, done_m, err_m;
    logic [1:0]  sel_a, sat_a, sel_m, sat_m;
    logic [11:0] trim_a, trim_m;
    logic [5:0]  tgt [2];

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_code [2][2];
    logic [1:0] exp_sat  [2];
    logic       exp_err  [2];

    always #5 clk = ~clk;

    ota_trim_cal_ctrl #(.NCH(NCH), .TRIM_W(TW), .SETTLE_CYC(SC), .CAL_MASK(MASK_A)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy_a), .cfg_ch(cfg_ch),
        .cfg_code(cfg_code), .cal_start(cal_start), .cmp_in(cmp_a), .busy(busy_a),
        .done(done_a), .cal_sel(sel_a), .trim_out(trim_a), .sat(sat_a), .err(err_a));

    ota_trim_cal_ctrl #(.NCH(NCH), .TRIM_W(TW), .SETTLE_CYC(SC), .CAL_MASK(MASK_M)) dut_m (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy_m), .cfg_ch(cfg_ch),
        .cfg_code(cfg_code), .cal_start(cal_start), .cmp_in(cmp_m), .busy(busy_m),
        .done(done_m), .cal_sel(sel_m), .trim_out(trim_m), .sat(sat_m), .err(err_m));

    // Analog comparator model: high when the selected channel's code exceeds its target.
    always_comb begin
        cmp_a = 1'b0;
        cmp_m = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_a[i] && (trim_a[i*TW +: TW] > tgt[i])) cmp_a = 1'b1;
            if (sel_m[i] && (trim_m[i*TW +: TW] > tgt[i])) cmp_m = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ref_sar(input int target);
        for (int c = 63; c >= 0; c--)
            if (!(c > target)) return 6'(c);
        return 6'd0;
    endfunction

    function automatic logic [11:0] trim_of(input int d); return (d == 1) ? trim_m : trim_a; endfunction
    function automatic logic [1:0]  sel_of (input int d); return (d == 1) ? sel_m  : sel_a;  endfunction
    function automatic logic [1:0]  sat_of (input int d); return (d == 1) ? sat_m  : sat_a;  endfunction
    function automatic logic        busy_of(input int d); return (d == 1) ? busy_m : busy_a; endfunction
    function automatic logic        done_of(input int d); return (d == 1) ? done_m : done_a; endfunction
    function automatic logic        rdy_of (input int d); return (d == 1) ? rdy_m  : rdy_a;  endfunction
    function automatic logic        err_of (input int d); return (d == 1) ? err_m  : err_a;  endfunction
    function automatic logic [1:0]  mask_of(input int d); return (d == 1) ? MASK_M : MASK_A; endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_codes(input string tag, input int d);
        check({tag, "_trim"}, trim_of(d), {exp_code[d][1], exp_code[d][0]});
        check({tag, "_sat"}, sat_of(d), exp_sat[d]);
        check({tag, "_err"}, err_of(d), exp_err[d]);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cal_start = 1'b0;
        cfg_valid = 1'b0;
        tick;
        for (int d = 0; d < 2; d++) begin
            exp_code[d][0] = 6'd32;
            exp_code[d][1] = 6'd32;
            exp_sat[d] = 2'b00;
            exp_err[d] = 1'b0;
            check_codes("reset", d);
            check("reset_busy", busy_of(d), 0);
            check("reset_ready", rdy_of(d), 1);
            check("reset_done", done_of(d), 0);
            check("reset_sel", sel_of(d), 0);
        end
        $display("reset applied");
        rst = 1'b0;
        tick;
    endtask

    task automatic do_write(input logic [2:0] ch, input logic [5:0] code);
        cfg_valid = 1'b1;
        cfg_ch = ch;
        cfg_code = code;
        tick;
        cfg_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (ch < 3'(NCH)) exp_code[d][ch[0]] = code;
            else exp_err[d] = 1'b1;
            check_codes("write", d);
        end
        $display("write ch=%0d code=%0h trim=%0h err=%0b", ch, code, trim_a, err_a);
    endtask

    task automatic run_cal(input int d, input logic [5:0] t0, input logic [5:0] t1,
                           input bit with_wr, input logic [5:0] wr_code, input bit poke);
        logic [1:0]  mask;
        logic [1:0]  seq[$];
        logic [1:0]  eq[$];
        logic [1:0]  s, prev;
        logic [11:0] tv;
        int          exp_lat, n, busy_bad, late_busy;
        bit          got_done;
        mask = mask_of(d);
        exp_lat = 1;
        for (int i = 0; i < NCH; i++)
            exp_lat += mask[i] ? (2 + TW * (SC + 1)) : 2;
        tgt[0] = t0;
        tgt[1] = t1;
        cal_start = 1'b1;
        if (with_wr) begin
            cfg_valid = 1'b1;
            cfg_ch = 3'd0;
            cfg_code = wr_code;
            exp_code[0][0] = wr_code;
            exp_code[1][0] = wr_code;
        end
        n = 0;
        got_done = 1'b0;
        busy_bad = 0;
        prev = '0;
        while (!got_done && n < 300) begin
            tick;
            n++;
            if (n == 1) begin
                cal_start = 1'b0;
                cfg_valid = 1'b0;
                check("ready_busy", rdy_of(d), 0);
                if (with_wr) begin
                    tv = trim_of(d);
                    check("wr_visible", tv[5:0], wr_code);
                end
            end
            if (n == 2 && with_wr && mask[0]) begin
                tv = trim_of(d);
                check("sel_midscale", tv[5:0], 6'd32);
            end
            if (poke && n == 10) begin
                cal_start = 1'b1;
                cfg_valid = 1'b1;
                cfg_ch = 3'd0;
                cfg_code = 6'h2A;
            end
            if (poke && n == 11) begin
                cal_start = 1'b0;
                cfg_valid = 1'b0;
            end
            if (busy_of(d) !== 1'b1) busy_bad++;
            s = sel_of(d);
            if (s != 2'b00 && s != prev) seq.push_back(s);
            prev = s;
            if (done_of(d)) got_done = 1'b1;
        end
        check("done_seen", 32'(got_done), 1);
        check("latency", n, exp_lat);
        check("busy_during", busy_bad, 0);
        for (int i = 0; i < NCH; i++)
            if (mask[i]) eq.push_back(2'(1 << i));
        check("sel_count", seq.size(), eq.size());
        for (int k = 0; k < eq.size() && k < seq.size(); k++)
            check("sel_order", seq[k], eq[k]);
        // The fully-masked instance finishes last, so both models are final then.
        for (int dd = 0; dd < 2; dd++) begin
            if (dd == d || d == 0) begin
                for (int i = 0; i < NCH; i++) begin
                    if (mask_of(dd)[i]) begin
                        exp_code[dd][i] = ref_sar(tgt[i]);
                        exp_sat[dd][i] = (exp_code[dd][i] == 6'd0) || (exp_code[dd][i] == 6'd63);
                    end
                end
            end
        end
        check_codes("cal_done", d);
        $display("cal dut=%0d tgt=%0d/%0d cycles=%0d trim=%0h sat=%0b", d, t0, t1, n, trim_of(d), sat_of(d));
        tick;
        check("post_busy", busy_of(d), 0);
        check("post_done", done_of(d), 0);
        check("post_sel", sel_of(d), 0);
        check("post_ready", rdy_of(d), 1);
        if (d == 0) check_codes("cal_other", 1);
        if (poke) begin
            late_busy = 0;
            for (int k = 0; k < 10; k++) begin
                tick;
                if (busy_of(d) !== 1'b0 || done_of(d) !== 1'b0) late_busy++;
            end
            check("no_restart", late_busy, 0);
        end
    endtask

    initial begin
        int dones;
        tgt[0] = '0;
        tgt[1] = '0;

        // Reset values, then reset in the middle of a sweep.
        do_reset;
        tgt[0] = 6'd40;
        tgt[1] = 6'd3;
        cal_start = 1'b1;
        tick;
        cal_start = 1'b0;
        for (int k = 0; k < 20; k++) tick;
        check("midsweep_busy", busy_a, 1);
        do_reset;
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            tick;
            if (done_a || done_m || busy_a) dones++;
        end
        check("abort_no_done", dones, 0);

        // Manual writes, out-of-range channel, sticky err.
        do_write(3'd1, 6'h15);
        do_write(3'd3, 6'h2C);
        for (int k = 0; k < 4; k++)
            do_write(3'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
        do_reset;

        // Calibration sweeps on the fully-masked instance.
        run_cal(0, 6'd37, 6'd10, 1'b0, 6'd0, 1'b0);
        run_cal(0, 6'd63, 6'd0, 1'b0, 6'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            do_write(3'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
            run_cal(0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b0, 6'd0, k[0]);
        end

        // Channel 0 skipped: preset code must survive, restart and writes while busy ignored.
        do_reset;
        do_write(3'd0, 6'h05);
        run_cal(1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b0, 6'd0, 1'b1);
        do_reset;

        // Write and start in the same cycle.
        run_cal(0, 6'd20, 6'($urandom_range(0, 63)), 1'b1, 6'h3F, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
